// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the byte-addressable lane data memory.
// Access-size encoding, FSM states and the byte-strobe generator.
package data_memory_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Strobe vector is wider than any supported word so that an access
    // running past the top lane shows up as set bits above LANES.
    localparam int MAX_LANES = 128;

    function automatic logic [MAX_LANES-1:0] byte_strobe(
        input size_t       size,
        input int unsigned offset,
        input int unsigned lanes
    );
        logic [MAX_LANES-1:0] mask;
        case (size)
            SIZE_BYTE: mask = MAX_LANES'(1);
            SIZE_HALF: mask = MAX_LANES'(3);
            SIZE_WORD: mask = (MAX_LANES'(1) << lanes) - MAX_LANES'(1);
            default:   mask = '0;
        endcase
        return mask << offset;
    endfunction

endpackage

// File: rtl/lane_steer.sv
// Combinational lane logic: store strobes and data replication on the request
// side, lane extraction and sign/zero extension on the registered load side.
module lane_steer
    import data_memory_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = DATA_WIDTH / 8,
    parameter int OFF        = $clog2(LANES)
) (
    input  logic [1:0]            i_Size,
    input  logic [OFF-1:0]        i_Offset,
    input  logic [DATA_WIDTH-1:0] i_Write_Data,
    output logic [LANES-1:0]      o_Strobe,
    output logic [DATA_WIDTH-1:0] o_Write_Data_Rep,
    output logic                  o_Misaligned,
    input  logic [1:0]            i_Load_Size,
    input  logic [OFF-1:0]        i_Load_Offset,
    input  logic                  i_Load_Signed,
    input  logic [DATA_WIDTH-1:0] i_Load_Word,
    output logic [DATA_WIDTH-1:0] o_Load_Data
);

    logic [MAX_LANES-1:0]  strobe_full;
    logic                  size_misalign;
    logic [DATA_WIDTH-1:0] shifted;

    assign strobe_full = byte_strobe(size_t'(i_Size), 32'(i_Offset), LANES);
    assign o_Strobe    = strobe_full[LANES-1:0];

    always_comb begin
        case (size_t'(i_Size))
            SIZE_BYTE: size_misalign = 1'b0;
            SIZE_HALF: size_misalign = i_Offset[0];
            SIZE_WORD: size_misalign = |i_Offset;
            default:   size_misalign = 1'b1;
        endcase
        // Any strobe bit beyond the top lane means the access left the word.
        o_Misaligned = size_misalign | (|strobe_full[MAX_LANES-1:LANES]);
    end

    always_comb begin
        case (size_t'(i_Size))
            SIZE_BYTE: o_Write_Data_Rep = {LANES{i_Write_Data[7:0]}};
            SIZE_HALF: o_Write_Data_Rep = {(LANES/2){i_Write_Data[15:0]}};
            default:   o_Write_Data_Rep = i_Write_Data;
        endcase
    end

    assign shifted = i_Load_Word >> {i_Load_Offset, 3'b000};

    always_comb begin
        case (size_t'(i_Load_Size))
            SIZE_BYTE: o_Load_Data = {{(DATA_WIDTH-8){i_Load_Signed & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: o_Load_Data = {{(DATA_WIDTH-16){i_Load_Signed & shifted[15]}}, shifted[15:0]};
            SIZE_WORD: o_Load_Data = shifted;
            default:   o_Load_Data = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_lanes.sv
// Byte-addressable data memory with registered read, valid/ready requests,
// fault detection and a post-reset clear engine; contents exposed on a flat bus.
module data_memory_lanes
    import data_memory_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int DATA_CAPACITY = 64,
    parameter int ADDR_WIDTH    = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                i_Request_Valid,
    output logic                                o_Request_Ready,
    input  logic                                i_Write_Enable,
    input  logic [1:0]                          i_Size,
    input  logic                                i_Signed,
    input  logic [ADDR_WIDTH-1:0]               i_Memory_Address,
    input  logic [DATA_WIDTH-1:0]               i_Memory_Write_Data,
    output logic                                o_Response_Valid,
    output logic [DATA_WIDTH-1:0]               o_Read_Data,
    output logic                                o_Fault,
    output logic                                o_Busy,
    output logic [DATA_WIDTH*DATA_CAPACITY-1:0] o_Data_Bus
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(LANES);
    localparam int IDXW  = ADDR_WIDTH - OFF;
    localparam int CAPW  = $clog2(DATA_CAPACITY);

    state_t            state_q, state_d;
    logic [CAPW-1:0]   clr_cnt_q, clr_cnt_d;
    logic              clr_we;

    logic [DATA_WIDTH-1:0] mem_q [DATA_CAPACITY];
    logic [DATA_WIDTH-1:0] rd_word_q;

    logic                  resp_valid_q;
    logic                  fault_q;
    logic                  load_q;
    logic [1:0]            size_q;
    logic [OFF-1:0]        off_q;
    logic                  signed_q;

    logic                  accept;
    logic [OFF-1:0]        offset;
    logic [IDXW-1:0]       word_idx_full;
    logic [CAPW-1:0]       word_idx;
    logic                  range_fault;
    logic                  misaligned;
    logic                  req_fault;
    logic                  wr_req;
    logic                  rd_req;
    logic [LANES-1:0]      strobe;
    logic [DATA_WIDTH-1:0] wdata_rep;
    logic [DATA_WIDTH-1:0] load_data;

    logic                  wr_en;
    logic [CAPW-1:0]       wr_addr;
    logic [LANES-1:0]      wr_strb;
    logic [DATA_WIDTH-1:0] wr_data;

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == CAPW'(DATA_CAPACITY - 1)) begin
                state_d = ST_READY;
            end
        end
    end

    // FSM: outputs
    always_comb begin
        o_Busy          = (state_q == ST_CLEAR);
        o_Request_Ready = (state_q == ST_READY);
        clr_we          = (state_q == ST_CLEAR);
    end

    assign accept        = i_Request_Valid & o_Request_Ready;
    assign offset        = i_Memory_Address[OFF-1:0];
    assign word_idx_full = i_Memory_Address[ADDR_WIDTH-1:OFF];
    assign word_idx      = word_idx_full[CAPW-1:0];
    assign range_fault   = word_idx_full > IDXW'(DATA_CAPACITY - 1);
    assign req_fault     = misaligned | range_fault;
    assign wr_req        = accept & i_Write_Enable & ~req_fault;
    assign rd_req        = accept & ~i_Write_Enable & ~req_fault;

    lane_steer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane_steer (
        .i_Size           (i_Size),
        .i_Offset         (offset),
        .i_Write_Data     (i_Memory_Write_Data),
        .o_Strobe         (strobe),
        .o_Write_Data_Rep (wdata_rep),
        .o_Misaligned     (misaligned),
        .i_Load_Size      (size_q),
        .i_Load_Offset    (off_q),
        .i_Load_Signed    (signed_q),
        .i_Load_Word      (rd_word_q),
        .o_Load_Data      (load_data)
    );

    // Single write port shared by the clear engine and stores.
    always_comb begin
        wr_en   = wr_req;
        wr_addr = word_idx;
        wr_strb = strobe;
        wr_data = wdata_rep;
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_addr = clr_cnt_q;
            wr_strb = '1;
            wr_data = '0;
        end
    end

    // Storage has no reset so it maps onto block RAM with byte enables.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < LANES; b++) begin
                if (wr_strb[b]) begin
                    mem_q[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
        if (rd_req) begin
            rd_word_q <= mem_q[word_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            load_q       <= 1'b0;
            size_q       <= SIZE_BYTE;
            off_q        <= '0;
            signed_q     <= 1'b0;
        end else begin
            resp_valid_q <= accept;
            fault_q      <= accept & req_fault;
            load_q       <= rd_req;
            if (accept) begin
                size_q   <= i_Size;
                off_q    <= offset;
                signed_q <= i_Signed;
            end
        end
    end

    assign o_Response_Valid = resp_valid_q;
    assign o_Fault          = fault_q;
    assign o_Read_Data      = load_q ? load_data : '0;

    for (genvar gi = 0; gi < DATA_CAPACITY; gi++) begin : g_bus
        assign o_Data_Bus[gi*DATA_WIDTH +: DATA_WIDTH] = mem_q[gi];
    end

endmodule

// File: doc/data_memory_lanes.md
# data_memory_lanes

Byte-addressable, parametrised successor to the single-cycle word data memory. It serves the load/store path with byte, halfword and full-width accesses, little-endian lane steering, sign/zero extension and alignment/range fault detection. A registered read port, a valid/ready request handshake and a sequential clear engine after reset make it mappable to synchronous block RAM. The full contents stay visible on a flat debug bus for the display/test harness.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits; power of two, ≥ 16
- DATA_CAPACITY, 64, number of words; power of two, ≥ 2
- ADDR_WIDTH, 32, byte-address width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- i_Request_Valid  in  1  request present
- o_Request_Ready  out  1  block can accept a request this cycle
- i_Write_Enable  in  1  1 = store, 0 = load
- i_Size  in  2  00 byte, 01 halfword, 10 full width, 11 reserved (faults)
- i_Signed  in  1  loads: sign-extend when 1, zero-extend when 0
- i_Memory_Address  in  ADDR_WIDTH  byte address
- i_Memory_Write_Data  in  DATA_WIDTH  store data, right-aligned
- o_Response_Valid  out  1  one-cycle pulse per accepted request
- o_Read_Data  out  DATA_WIDTH  extended load data; 0 for stores and faults
- o_Fault  out  1  qualifies o_Response_Valid; misaligned, out-of-range or reserved size
- o_Busy  out  1  clear engine running
- o_Data_Bus  out  DATA_WIDTH*DATA_CAPACITY  word k at bits [k*DATA_WIDTH +: DATA_WIDTH]

## Operation
- LANES = DATA_WIDTH/8, OFF = log2(LANES). Lane offset = address[OFF-1:0]. Word index = address >> OFF.
- FSM states:
  - CLEAR: a counter walks 0..DATA_CAPACITY-1 and writes one zero word per cycle. o_Busy=1, o_Request_Ready=0. After the final index, go to READY.
  - READY: o_Request_Ready=1, o_Busy=0. Stay here until reset.
- Accept a request when i_Request_Valid && o_Request_Ready at a rising edge. Throughput is one request per cycle.
- Fault conditions:
  - halfword at an odd offset
  - full width at a nonzero offset
  - i_Size=11
  - word index ≥ DATA_CAPACITY
  - On fault: no memory change, o_Read_Data=0, o_Fault=1.
- Store: byte strobe = size mask shifted left by the lane offset. The byte is written from i_Memory_Write_Data[7:0] into lane offset; the halfword from [15:0]. Unstrobed lanes are preserved.
- Load: take the selected lanes, shift them down to bit 0, then sign- or zero-extend to DATA_WIDTH. Full-width loads ignore i_Signed.
- o_Data_Bus is a combinational view of the storage array.

## Timing
- While reset is asserted: FSM=CLEAR, counter=0, o_Request_Ready=0, o_Busy=1, o_Response_Valid=0, o_Read_Data=0, o_Fault=0. o_Data_Bus is unspecified until o_Busy falls.
- After reset deasserts, the clear takes exactly DATA_CAPACITY cycles. o_Request_Ready rises on the edge that writes the last index.
- Reset asserted mid-clear or mid-operation: abort and restart CLEAR from index 0. A pending response is dropped.
- Response latency is 1 cycle. o_Response_Valid, o_Read_Data and o_Fault are registered and valid in the cycle after the accepting edge. Outputs return to 0 the following cycle unless another request was accepted.
- A store is visible on o_Data_Bus and to a load accepted on the next edge. Back-to-back store then load of the same address returns the new data.
- Requests presented while o_Request_Ready=0 are ignored. No response is generated for them.

## Structure
- Shared package data_memory_pkg:
  - size_t enum (SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_RSVD)
  - state_t enum (ST_CLEAR, ST_READY)
  - function computing byte strobe from size and offset
- One sub-module, lane_steer: combinational strobe generation, store-data replication, load extraction and extension. The top holds the FSM, the clear counter, the storage array and the response registers.

## Test plan
- Reset, DATA_CAPACITY=16: release reset. o_Busy is high for 16 cycles, then o_Request_Ready=1. All o_Data_Bus words = 0.
- Store full-width 0xDEADBEEF at address 0x8, then byte-load 0x9 signed: response 0xFFFFFFBE, fault 0. Same load unsigned: 0x000000BE.
- Store byte 0x5A at 0xB over 0xDEADBEEF: word 2 becomes 0x5AADBEEF. Halfword load 0xA signed: 0x00005AAD.
- Misaligned halfword store to 0x3 and full-width load at 0x6: o_Fault=1, o_Read_Data=0, memory unchanged.
- Out-of-range load at word index 16 (address 0x40, 16 words): fault.
- Size 11: fault. Reset pulse mid-clear at index 7: clear restarts and takes the full 16 cycles.
